// File: rtl/pwc_pkg.sv
// Shared types and sizing helpers for the pulse window checker.
// PWC_STUCK_DETECT_EN widens the window counters to track stuck-high pulses.
package pwc_pkg;

   typedef enum logic {LOW, HIGH} pwc_state_t;

   localparam int PWC_EXP_WIDTH = 3;
   localparam int PWC_MIN_GAP   = 4;

   // Window counters must hold both the high-side saturation value and MIN_GAP.
   function automatic int win_cnt_w(input int exp_width, input int min_gap);
      int hi_sat;
      int top;
`ifdef PWC_STUCK_DETECT_EN
      hi_sat = 2 * exp_width + 1;
`else
      hi_sat = exp_width + 1;
`endif
      top = (hi_sat > min_gap) ? hi_sat : min_gap;
      return $clog2(top + 1);
   endfunction

   localparam int WIN_CNT_W = win_cnt_w(PWC_EXP_WIDTH, PWC_MIN_GAP);

endpackage

// File: rtl/pulse_window_checker_sat_counter.sv
// Saturating up-counter with synchronous clear and load-of-one.
// Priority: clr, then load_one, then inc.
module sat_counter #(
   parameter int           W       = 8,
   parameter logic [W-1:0] MAX     = '1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load_one,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= RST_VAL;
      else if (clr)
         count <= '0;
      else if (load_one)
         count <= W'(1);
      else if (inc && (count != MAX))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pulse_window_checker.sv
// Classifies detector window pulses by high width and preceding low gap.
// Define PWC_STUCK_DETECT_EN to add the stuck_high output.
//
// state | meaning
// LOW   | pulse_in low, counting gap cycles in lo_cnt
// HIGH  | pulse_in high, counting width cycles in hi_cnt
module pulse_window_checker
   import pwc_pkg::*;
#(
   parameter int EXP_WIDTH = PWC_EXP_WIDTH,
   parameter int MIN_GAP   = PWC_MIN_GAP,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clr,
   output logic             valid_pulse,
   output logic             err_width,
   output logic             err_gap,
   output logic             err_sticky,
   output logic [CNT_W-1:0] pulse_count
`ifdef PWC_STUCK_DETECT_EN
   ,
   output logic             stuck_high
`endif
);

   localparam int WIN_W = win_cnt_w(EXP_WIDTH, MIN_GAP);
`ifdef PWC_STUCK_DETECT_EN
   localparam int HI_SAT = 2 * EXP_WIDTH + 1;
   localparam logic [WIN_W-1:0] STUCK_AT = WIN_W'(2 * EXP_WIDTH);
`else
   localparam int HI_SAT = EXP_WIDTH + 1;
`endif
   localparam logic [WIN_W-1:0] HI_MAX    = WIN_W'(HI_SAT);
   localparam logic [WIN_W-1:0] GAP_MIN   = WIN_W'(MIN_GAP);
   localparam logic [WIN_W-1:0] WIDTH_EXP = WIN_W'(EXP_WIDTH);

   pwc_state_t       state;
   logic             gap_ok;
   logic [WIN_W-1:0] hi_cnt;
   logic [WIN_W-1:0] lo_cnt;
   logic             rise, fall, gap_now, width_ok, count_inc, stuck_set;

   assign rise      = (state == LOW) && pulse_in;
   assign fall      = (state == HIGH) && !pulse_in;
   assign gap_now   = (lo_cnt >= GAP_MIN);
   assign width_ok  = (hi_cnt == WIDTH_EXP);
   assign count_inc = fall && width_ok && gap_ok;

`ifdef PWC_STUCK_DETECT_EN
   assign stuck_set = (state == HIGH) && pulse_in && (hi_cnt >= STUCK_AT) && !stuck_high;
`else
   assign stuck_set = 1'b0;
`endif

   sat_counter #(.W(WIN_W), .MAX(HI_MAX), .RST_VAL('0)) u_hi_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load_one (rise),
      .inc      ((state == HIGH) && pulse_in),
      .count    (hi_cnt)
   );

   // lo_cnt resets to MIN_GAP so the first pulse after reset has a qualified gap.
   sat_counter #(.W(WIN_W), .MAX(GAP_MIN), .RST_VAL(GAP_MIN)) u_lo_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load_one (fall),
      .inc      ((state == LOW) && !pulse_in),
      .count    (lo_cnt)
   );

   sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}}), .RST_VAL('0)) u_pulse_count (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load_one (1'b0),
      .inc      (count_inc),
      .count    (pulse_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= LOW;
         gap_ok      <= 1'b0;
         valid_pulse <= 1'b0;
         err_width   <= 1'b0;
         err_gap     <= 1'b0;
         err_sticky  <= 1'b0;
`ifdef PWC_STUCK_DETECT_EN
         stuck_high  <= 1'b0;
`endif
      end else begin
         valid_pulse <= 1'b0;
         err_width   <= 1'b0;
         err_gap     <= 1'b0;
         case (state)
            LOW: begin
               if (pulse_in) begin
                  state   <= HIGH;
                  gap_ok  <= gap_now;
                  err_gap <= !gap_now;
               end
            end
            HIGH: begin
               if (!pulse_in) begin
                  state       <= LOW;
                  valid_pulse <= width_ok && gap_ok;
                  err_width   <= !width_ok;
               end
            end
            default: state <= LOW;
         endcase
`ifdef PWC_STUCK_DETECT_EN
         if (fall)
            stuck_high <= 1'b0;
         else if (stuck_set)
            stuck_high <= 1'b1;
`endif
         if (clr)
            err_sticky <= 1'b0;
         else if ((rise && !gap_now) || (fall && !width_ok) || stuck_set)
            err_sticky <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pulse_window_checker.sv
// Scoreboard bench for pulse_window_checker: a cycle model queues expected outputs
// at drive time and a monitor pops and compares them after each rising edge.
module tb_pulse_window_checker;

   localparam int EXP_WIDTH = 3;
   localparam int MIN_GAP   = 4;
   localparam int CNT_W     = 8;
`ifdef PWC_STUCK_DETECT_EN
   localparam bit STUCK_EN = 1'b1;
   localparam int HI_SAT   = 2 * EXP_WIDTH + 1;
`else
   localparam bit STUCK_EN = 1'b0;
   localparam int HI_SAT   = EXP_WIDTH + 1;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             pulse_in = 1'b0;
   logic             clr = 1'b0;
   logic             valid_pulse, err_width, err_gap, err_sticky;
   logic [CNT_W-1:0] pulse_count;
   logic             stuck_high;

   pulse_window_checker #(
      .EXP_WIDTH (EXP_WIDTH),
      .MIN_GAP   (MIN_GAP),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .clr         (clr),
      .valid_pulse (valid_pulse),
      .err_width   (err_width),
      .err_gap     (err_gap),
      .err_sticky  (err_sticky),
      .pulse_count (pulse_count)
`ifdef PWC_STUCK_DETECT_EN
      ,
      .stuck_high  (stuck_high)
`endif
   );

`ifndef PWC_STUCK_DETECT_EN
   assign stuck_high = 1'b0;
`endif

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int n_ew     = 0;
   int n_eg     = 0;
   int n_stuck  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Cycle model of the spec behaviour
   bit m_high, m_gapok, m_valid, m_ew, m_eg, m_sticky, m_stuck;
   int m_hi, m_lo, m_cnt;

   task automatic model(input logic p, input logic c, input logic r);
      bit sset;
      sset = 1'b0;
      if (r) begin
         m_high = 0; m_gapok = 0; m_valid = 0; m_ew = 0; m_eg = 0;
         m_sticky = 0; m_stuck = 0; m_hi = 0; m_lo = MIN_GAP; m_cnt = 0;
         return;
      end
      m_valid = 0; m_ew = 0; m_eg = 0;
      if (!m_high) begin
         if (p) begin
            m_high = 1; m_hi = 1;
            m_gapok = (m_lo >= MIN_GAP);
            m_eg = !m_gapok;
         end else if (m_lo < MIN_GAP) begin
            m_lo++;
         end
      end else if (p) begin
         if (STUCK_EN && m_hi >= 2 * EXP_WIDTH && !m_stuck) begin
            m_stuck = 1; sset = 1;
         end
         if (m_hi < HI_SAT) m_hi++;
      end else begin
         m_high = 0; m_lo = 1; m_stuck = 0;
         if (m_hi == EXP_WIDTH) m_valid = m_gapok;
         else m_ew = 1;
      end
      if (c) m_cnt = 0;
      else if (m_valid && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (c) m_sticky = 0;
      else if (m_ew || m_eg || sset) m_sticky = 1;
   endtask

   logic [12:0] exp_q[$];

   task automatic step(input logic p, input logic c, input logic r);
      @(negedge clk);
      pulse_in = p; clr = c; rst = r;
      model(p, c, r);
      exp_q.push_back({m_valid, m_ew, m_eg, m_sticky, m_stuck, 8'(m_cnt)});
   endtask

   task automatic lows(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic highs(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      logic [12:0] e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("outputs", {19'd0, valid_pulse, err_width, err_gap, err_sticky, stuck_high, pulse_count},
               {19'd0, e});
         n_valid += int'(valid_pulse);
         n_ew    += int'(err_width);
         n_eg    += int'(err_gap);
         n_stuck += int'(stuck_high);
      end
   end

   initial begin
      int v0, w0, g0, gap, wid;

      model(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      settle();
      check("reset_state", {27'd0, valid_pulse, err_width, err_gap, err_sticky, stuck_high}, 32'd0);
      check("reset_count", {24'd0, pulse_count}, 32'd0);

      // Well-formed pulse
      lows(4); highs(3); lows(2);
      settle();
      check("t1_count", {24'd0, pulse_count}, 32'd1);
      check("t1_valid_n", n_valid, 1);

      // Short pulse, then clear
      lows(4); highs(2); lows(2);
      settle();
      check("t2_sticky", {31'd0, err_sticky}, 32'd1);
      check("t2_count", {24'd0, pulse_count}, 32'd1);
      step(1'b0, 1'b1, 1'b0);
      lows(1);
      settle();
      check("t2_sticky_clr", {31'd0, err_sticky}, 32'd0);

      // Short gap after a valid pulse, then 1-cycle back-to-back
      lows(4); highs(3); lows(2); highs(3); lows(4);
      highs(3); lows(1); highs(3); lows(4);
      settle();
      check("t3_err_gap_n", n_eg, 2);
      check("t3_count", {24'd0, pulse_count}, 32'd2);
      step(1'b0, 1'b1, 1'b0);

      // Saturation, then clr coincident with a valid pulse
      for (int i = 0; i < 260; i++) begin
         lows(4); highs(3);
      end
      lows(2);
      settle();
      check("t4_saturate", {24'd0, pulse_count}, 32'd255);
      lows(4); highs(3);
      step(1'b0, 1'b1, 1'b0);
      lows(1);
      settle();
      check("t4_clr_valid", {24'd0, pulse_count}, 32'd0);

      // Reset during the 2nd high cycle, released with pulse_in still high
      v0 = n_valid; w0 = n_ew;
      lows(4); highs(1);
      step(1'b1, 1'b0, 1'b1);
      highs(3); lows(3);
      settle();
      check("t5_valid_once", n_valid - v0, 1);
      check("t5_no_err_width", n_ew - w0, 0);

`ifdef PWC_STUCK_DETECT_EN
      n_stuck = 0; w0 = n_ew;
      lows(4); highs(10); lows(2);
      settle();
      check("t6_stuck_cycles", n_stuck, 4);
      check("t6_err_width", n_ew - w0, 1);
      check("t6_sticky", {31'd0, err_sticky}, 32'd1);
`endif

      // Random pulse trains with occasional clr
      for (int i = 0; i < 60; i++) begin
         gap = int'($urandom_range(1, 6));
         wid = int'($urandom_range(1, 9));
         for (int j = 0; j < gap; j++) step(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
         for (int j = 0; j < wid; j++) step(1'b1, ($urandom_range(0, 15) == 0), 1'b0);
      end
      lows(3);
      settle();
      settle();
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
